// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage.
// Issues one req/ack data-bus transaction per load/store, stalls the pipe
// until the bus answers, formats load data and forwards the writeback fields
// to MEM/WB. A bus timeout becomes an access fault in exception_o.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_int_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic [4:0]        reg_waddr_i,
    output logic [4:0]        reg_waddr_o,
    input  logic              reg_we_i,
    output logic              reg_we_o,
    input  logic [DATA_W-1:0] reg_wdata_i,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] exception_i,
    output logic [DATA_W-1:0] exception_o,
    input  logic              csr_we_i,
    input  logic [11:0]       csr_waddr_i,
    input  logic [DATA_W-1:0] csr_wdata_i,
    output logic              csr_we_o,
    output logic [11:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              stall_req_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // Fault nibble layout, placed at exception bits [7:4]
    localparam logic [3:0] F_LD_MIS = 4'b0001;   // bit 4
    localparam logic [3:0] F_LD_TMO = 4'b0010;   // bit 5
    localparam logic [3:0] F_ST_MIS = 4'b0100;   // bit 6
    localparam logic [3:0] F_ST_TMO = 4'b1000;   // bit 7

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              load_reg;
    logic              unsigned_reg;
    logic [1:0]        size_reg;
    logic [1:0]        addr_lo_reg;
    logic              kill_reg;
    logic [3:0]        fault_reg;
    logic [DATA_W-1:0] load_data_reg;

    logic              op_load;
    logic              op_store;
    logic              op_unsigned;
    logic [1:0]        op_size;
    logic              op_valid;
    logic              issue;
    logic              misaligned;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] fault_vec;

    // Store direction is taken from the opcode decode; mem_we_i carries the
    // same information and is not needed for any decision here.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    // Fields that never change in this stage
    assign inst_addr_o = inst_addr_i;
    assign reg_waddr_o = reg_waddr_i;
    assign csr_waddr_o = csr_waddr_i;
    assign csr_wdata_o = csr_wdata_i;

    // Pick the addressed byte/half out of the read word and extend it
    function automatic logic [DATA_W-1:0] format_load(
        input logic [DATA_W-1:0] rd,
        input logic [1:0]        lo,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = rd[{lo, 3'b000} +: 8];
        h = rd[{lo[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    res = uns ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
            SZ_H:    res = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Decode mem_op into direction, access size and extension
    always_comb begin
        op_load     = 1'b0;
        op_store    = 1'b0;
        op_unsigned = 1'b0;
        op_size     = SZ_W;
        case (mem_op_i)
            OP_LB:   begin op_load = 1'b1;  op_size = SZ_B; end
            OP_LH:   begin op_load = 1'b1;  op_size = SZ_H; end
            OP_LW:   begin op_load = 1'b1;  op_size = SZ_W; end
            OP_LBU:  begin op_load = 1'b1;  op_size = SZ_B; op_unsigned = 1'b1; end
            OP_LHU:  begin op_load = 1'b1;  op_size = SZ_H; op_unsigned = 1'b1; end
            OP_SB:   begin op_store = 1'b1; op_size = SZ_B; end
            OP_SH:   begin op_store = 1'b1; op_size = SZ_H; end
            OP_SW:   begin op_store = 1'b1; op_size = SZ_W; end
            default: begin op_load = 1'b0;  op_store = 1'b0; end
        endcase
    end

    assign op_valid = op_load | op_store;
    // An instruction already carrying an exception, or being flushed, never touches the bus
    assign issue    = op_valid && (exception_i == '0) && !flush_int_i;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = op_valid &&
                        (((op_size == SZ_H) && mem_addr_i[0]) ||
                         ((op_size == SZ_W) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the pending access
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = '0;
        if (op_store) begin
            case (op_size)
                SZ_B: begin
                    be_next    = 4'b0001 << mem_addr_i[1:0];
                    wdata_next = {(DATA_W/8){mem_data_i[7:0]}};
                end
                SZ_H: begin
                    be_next    = 4'b0011 << {mem_addr_i[1], 1'b0};
                    wdata_next = {(DATA_W/16){mem_data_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = mem_data_i;
                end
            endcase
        end
    end

    // Fault nibble widened to the exception vector
    always_comb begin
        fault_vec      = '0;
        fault_vec[7:4] = fault_reg;
    end

    // Stage FSM: owns the bus outputs, timeout counter and captured load data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= S_IDLE;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_be_o      <= 4'b0000;
            bus_wdata_o   <= '0;
            cnt_reg       <= '0;
            load_reg      <= 1'b0;
            unsigned_reg  <= 1'b0;
            size_reg      <= SZ_B;
            addr_lo_reg   <= 2'b00;
            kill_reg      <= 1'b0;
            fault_reg     <= 4'b0000;
            load_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    kill_reg  <= 1'b0;
                    fault_reg <= 4'b0000;
                    if (issue) begin
                        if (misaligned) begin
                            // Trap without touching the bus
                            load_reg  <= 1'b0;
                            fault_reg <= op_store ? F_ST_MIS : F_LD_MIS;
                            state_reg <= S_DONE;
                        end else begin
                            bus_req_o    <= 1'b1;
                            bus_we_o     <= op_store;
                            bus_addr_o   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                            bus_be_o     <= be_next;
                            bus_wdata_o  <= wdata_next;
                            cnt_reg      <= '0;
                            load_reg     <= op_load;
                            unsigned_reg <= op_unsigned;
                            size_reg     <= op_size;
                            addr_lo_reg  <= mem_addr_i[1:0];
                            state_reg    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // A flush cannot abort the bus cycle; it only squashes the result
                    if (flush_int_i) begin
                        kill_reg <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        load_data_reg <= format_load(bus_rdata_i, addr_lo_reg, size_reg, unsigned_reg);
                        bus_req_o     <= 1'b0;
                        bus_we_o      <= 1'b0;
                        state_reg     <= S_DONE;
                    end else if (cnt_reg == CNT_MAX) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        fault_reg <= bus_we_o ? F_ST_TMO : F_LD_TMO;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Writeback fields and stall request, derived from state and the current instruction
    always_comb begin
        stall_req_o = 1'b0;
        reg_we_o    = reg_we_i;
        csr_we_o    = csr_we_i;
        exception_o = exception_i;
        reg_wdata_o = reg_wdata_i;
        if (!rst_n_i) begin
            reg_we_o    = 1'b0;
            csr_we_o    = 1'b0;
            exception_o = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (flush_int_i) begin
                        reg_we_o    = 1'b0;
                        csr_we_o    = 1'b0;
                        exception_o = '0;
                    end else if (issue) begin
                        // Bubble downstream while the access is in flight
                        stall_req_o = 1'b1;
                        reg_we_o    = 1'b0;
                        csr_we_o    = 1'b0;
                        exception_o = '0;
                    end
                end
                S_BUSY: begin
                    stall_req_o = 1'b1;
                    reg_we_o    = 1'b0;
                    csr_we_o    = 1'b0;
                    exception_o = '0;
                end
                S_DONE: begin
                    if (kill_reg || flush_int_i) begin
                        reg_we_o    = 1'b0;
                        csr_we_o    = 1'b0;
                        exception_o = '0;
                    end else begin
                        reg_wdata_o = load_reg ? load_data_reg : reg_wdata_i;
                        reg_we_o    = reg_we_i && (fault_reg == 4'b0000);
                        exception_o = exception_i | fault_vec;
                    end
                end
                default: begin
                    stall_req_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
// Follows MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access;

    localparam int TO = 6;
    localparam logic [31:0] ALU = 32'h5A5A_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_int_i;
    logic [31:0] inst_addr_i, inst_addr_o;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        reg_we_i, reg_we_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic [31:0] mem_addr_i, mem_data_i;
    logic        mem_we_i;
    logic [3:0]  mem_op_i;
    logic [31:0] exception_i, exception_o;
    logic        csr_we_i, csr_we_o;
    logic [11:0] csr_waddr_i, csr_waddr_o;
    logic [31:0] csr_wdata_i, csr_wdata_o;
    logic        stall_req_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_access #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_int_i(flush_int_i),
        .inst_addr_i(inst_addr_i), .inst_addr_o(inst_addr_o),
        .reg_waddr_i(reg_waddr_i), .reg_waddr_o(reg_waddr_o),
        .reg_we_i(reg_we_i), .reg_we_o(reg_we_o),
        .reg_wdata_i(reg_wdata_i), .reg_wdata_o(reg_wdata_o),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i),
        .mem_op_i(mem_op_i), .exception_i(exception_i), .exception_o(exception_o),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .stall_req_o(stall_req_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
        return 4;
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] addr);
        bit en;
        en = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        en = 1'b1;
`endif
        return en && ((m_size(op) == 2 && (addr % 2) != 0) || (m_size(op) == 4 && (addr % 4) != 0));
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
        int v;
        if (!m_store(op)) return 4'hF;
        case (m_size(op))
            1:       v = 1 << (addr % 4);
            2:       v = 3 << (addr & 2);
            default: v = 15;
        endcase
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (m_size(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        bit uns;
        uns = (op == 4'd4) || (op == 4'd5);
        if (m_size(op) == 1) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (m_size(op) == 2) begin
            v = (rd >> (8 * (addr & 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- one full stage transaction ----------------
    // dly: BUSY cycle index carrying ack (-1 = never); fl: BUSY cycle index of flush pulse (-1 = none)
    task automatic run_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int dly, input int fl,
                           input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input logic [31:0] e_res, input logic [31:0] e_exc, input logic e_we);
        int stalls, busy, e_busy;
        bit st, miss;
        st   = m_store(op);
        miss = (e_exc[4] | e_exc[6]);
        e_busy = miss ? 0 : ((dly >= 0 && dly <= TO) ? dly + 1 : TO + 1);
        mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = st;
        reg_we_i = 1'b1; reg_wdata_i = ALU; exception_i = '0; csr_we_i = 1'b0;
        flush_int_i = 1'b0; bus_ack_i = 1'b0;
        stalls = 0; busy = 0;
        #1;
        check({tag, ".issue_bubble_we"}, {31'd0, reg_we_o}, 32'd0);
        if (stall_req_o) stalls++;
        @(posedge clk_i); #1;
        while (bus_req_o && busy <= TO + 2) begin
            if (stall_req_o) stalls++;
            check({tag, ".bus_addr"}, bus_addr_o, e_addr);
            if (busy == 0) begin
                check({tag, ".bus_be"}, {28'd0, bus_be_o}, {28'd0, e_be});
                check({tag, ".bus_we"}, {31'd0, bus_we_o}, {31'd0, st});
                if (st) check({tag, ".bus_wdata"}, bus_wdata_o, e_wdata);
            end
            flush_int_i = (busy == fl);
            bus_ack_i   = (busy == dly);
            bus_rdata_i = bus_ack_i ? rdata : $urandom;
            @(posedge clk_i); #1;
            busy++;
        end
        flush_int_i = 1'b0; bus_ack_i = 1'b0;
        check({tag, ".busy_cycles"}, busy, e_busy);
        check({tag, ".stall_cycles"}, stalls, 1 + e_busy);
        check({tag, ".done_stall"}, {31'd0, stall_req_o}, 32'd0);
        check({tag, ".done_reg_we"}, {31'd0, reg_we_o}, {31'd0, e_we});
        check({tag, ".done_exc"}, exception_o, e_exc);
        if (e_we) check({tag, ".done_wdata"}, reg_wdata_o, e_res);
        $display("txn %s op=%0d addr=0x%08h busy=%0d stalls=%0d wdata=0x%08h exc=0x%08h",
                 tag, op, addr, busy, stalls, reg_wdata_o, exception_o);
        @(posedge clk_i); #1;
        mem_op_i = 4'd0;
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          dly;
        int          fl;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic [31:0] e_exc;
        logic        e_we;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Directed vectors with hand-computed expectations
        vecs[0]  = '{"lw_100",   4'd3, 32'h100, 32'h0,        32'hDEADBEEF, 1,  -1, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 32'h0,  1'b1};
        vecs[1]  = '{"lb_103",   4'd1, 32'h103, 32'h0,        32'h80000000, 0,  -1, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80, 32'h0,  1'b1};
        vecs[2]  = '{"lbu_103",  4'd4, 32'h103, 32'h0,        32'h80000000, 0,  -1, 32'h100, 4'hF, 32'h0,        32'h00000080, 32'h0,  1'b1};
        vecs[3]  = '{"lhu_102",  4'd5, 32'h102, 32'h0,        32'hBEEF0000, 2,  -1, 32'h100, 4'hF, 32'h0,        32'h0000BEEF, 32'h0,  1'b1};
        vecs[4]  = '{"lh_102",   4'd2, 32'h102, 32'h0,        32'h80010000, 0,  -1, 32'h100, 4'hF, 32'h0,        32'hFFFF8001, 32'h0,  1'b1};
        vecs[5]  = '{"sb_201",   4'd6, 32'h201, 32'h000000A5, 32'h0,        0,  -1, 32'h200, 4'h2, 32'hA5A5A5A5, ALU,          32'h0,  1'b1};
        vecs[6]  = '{"sh_202",   4'd7, 32'h202, 32'h1234BEEF, 32'h0,        1,  -1, 32'h200, 4'hC, 32'hBEEFBEEF, ALU,          32'h0,  1'b1};
        vecs[7]  = '{"sw_tmo",   4'd8, 32'h204, 32'h12345678, 32'h0,        -1, -1, 32'h204, 4'hF, 32'h12345678, ALU,          32'h80, 1'b0};
        vecs[8]  = '{"lw_tmo",   4'd3, 32'h300, 32'h0,        32'h0,        -1, -1, 32'h300, 4'hF, 32'h0,        32'h0,        32'h20, 1'b0};
        vecs[9]  = '{"lw_flush", 4'd3, 32'h104, 32'h0,        32'h11223344, 3,  1,  32'h104, 4'hF, 32'h0,        32'h0,        32'h0,  1'b0};
        vecs[10] = '{"sw_ackto", 4'd8, 32'h010, 32'hCAFEF00D, 32'h0,        TO, -1, 32'h010, 4'hF, 32'hCAFEF00D, ALU,          32'h0,  1'b1};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[11] = '{"lw_102",   4'd3, 32'h102, 32'h0,        32'h55667788, 0,  -1, 32'h0,   4'hF, 32'h0,        32'h0,        32'h10, 1'b0};
`else
        vecs[11] = '{"lw_102",   4'd3, 32'h102, 32'h0,        32'h55667788, 0,  -1, 32'h100, 4'hF, 32'h0,        32'h55667788, 32'h0,  1'b1};
`endif

        // Reset state, with inputs asking for writes and an exception
        rst_n_i = 1'b0; flush_int_i = 1'b0; inst_addr_i = 32'h8000_0000; reg_waddr_i = 5'd7;
        reg_we_i = 1'b1; reg_wdata_i = ALU; mem_addr_i = 32'h100; mem_data_i = '0; mem_we_i = 1'b0;
        mem_op_i = 4'd3; exception_i = 32'h5; csr_we_i = 1'b1; csr_waddr_i = 12'h305;
        csr_wdata_i = 32'h1234; bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.reg_we", {31'd0, reg_we_o}, 32'd0);
        check("rst.csr_we", {31'd0, csr_we_o}, 32'd0);
        check("rst.exc", exception_o, 32'd0);
        check("rst.bus_req", {31'd0, bus_req_o}, 32'd0);
        check("rst.bus_be", {28'd0, bus_be_o}, 32'd0);
        check("rst.bus_addr", bus_addr_o, 32'd0);
        check("rst.stall", {31'd0, stall_req_o}, 32'd0);
        #3 rst_n_i = 1'b1;
        mem_op_i = 4'd0; exception_i = '0;
        @(posedge clk_i); #1;

        // IDLE passthrough of a non-memory instruction
        reg_wdata_i = 32'h0BAD_F00D;
        #1;
        check("pass.reg_we", {31'd0, reg_we_o}, 32'd1);
        check("pass.reg_wdata", reg_wdata_o, 32'h0BAD_F00D);
        check("pass.csr_we", {31'd0, csr_we_o}, 32'd1);
        check("pass.csr_wdata", csr_wdata_o, 32'h1234);
        check("pass.inst_addr", inst_addr_o, 32'h8000_0000);
        check("pass.stall", {31'd0, stall_req_o}, 32'd0);

        // Memory op already carrying an exception: passthrough, no bus cycle
        mem_op_i = 4'd3; exception_i = 32'h4;
        #1;
        check("exc_in.stall", {31'd0, stall_req_o}, 32'd0);
        check("exc_in.exc", exception_o, 32'h4);
        @(posedge clk_i); #1;
        check("exc_in.bus_req", {31'd0, bus_req_o}, 32'd0);
        exception_i = '0;

        // Flush while IDLE with a valid op: squashed, no bus cycle
        flush_int_i = 1'b1;
        #1;
        check("flush_idle.reg_we", {31'd0, reg_we_o}, 32'd0);
        check("flush_idle.csr_we", {31'd0, csr_we_o}, 32'd0);
        check("flush_idle.stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk_i); #1;
        check("flush_idle.bus_req", {31'd0, bus_req_o}, 32'd0);
        flush_int_i = 1'b0; mem_op_i = 4'd0; csr_we_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset asserted mid-BUSY drops the request immediately
        mem_op_i = 4'd3; mem_addr_i = 32'h400;
        @(posedge clk_i); #1;
        check("rst_busy.req_before", {31'd0, bus_req_o}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_busy.req_after", {31'd0, bus_req_o}, 32'd0);
        check("rst_busy.stall", {31'd0, stall_req_o}, 32'd0);
        mem_op_i = 4'd0;
        #3 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].tag, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].rdata,
                    vecs[i].dly, vecs[i].fl, vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata,
                    vecs[i].e_res, vecs[i].e_exc, vecs[i].e_we);
        end

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] addr, data, rd, e_exc, e_res;
            int          r, dly, fl;
            bit          miss, tmo, kill, st;
            op   = 4'($urandom_range(1, 8));
            addr = $urandom & 32'h0000_FFFF;
            data = $urandom;
            rd   = $urandom;
            r    = $urandom_range(0, 9);
            fl   = -1;
            if (r < 6)       dly = r % 4;
            else if (r == 6) dly = -1;
            else if (r == 7) dly = TO;
            else if (r == 8) begin dly = 1; fl = 0; end
            else             begin dly = 2; fl = 1; end
            st   = m_store(op);
            miss = m_mis(op, addr);
            tmo  = !miss && (dly < 0 || dly > TO);
            kill = !miss && (fl >= 0);
            if (kill)      e_exc = 32'h0;
            else if (miss) e_exc = st ? 32'h40 : 32'h10;
            else if (tmo)  e_exc = st ? 32'h80 : 32'h20;
            else           e_exc = 32'h0;
            e_res = st ? ALU : m_load(op, addr, rd);
            run_txn($sformatf("rnd%0d", i), op, addr, data, rd, dly, fl,
                    addr & 32'hFFFF_FFFC, m_be(op, addr), m_wdata(op, data),
                    e_res, e_exc, !kill && (e_exc == 32'h0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
